apuf_eval_ctrl: RTL
===================

APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 Parameter CHAL_W SHALL be: default 64; challenge width, equal to the switch-chain stage count.
REQ-002 Parameter SETTLE_CYC SHALL be: default 8; cycles per relax phase and per race phase; legal range 3..255.
REQ-003 Parameter NUM_EVAL SHALL be: default 15; races per challenge for the majority vote; odd, 1..255.
REQ-004 Port clk SHALL be: input, 1 bit; single clock; all state on rising edge.
REQ-005 Port rst_n SHALL be: input, 1 bit; reset, asynchronous and active-low.
REQ-006 Port start SHALL be: input, 1 bit; request evaluation of chal_in.
REQ-007 Port chal_in SHALL be: input, CHAL_W bits; challenge, sampled on start acceptance.
REQ-008 Port busy SHALL be: output, 1 bit; high from start acceptance until the response handshake completes.
REQ-009 Port chal_out SHALL be: output, CHAL_W bits; registered challenge driving the switch-stage c inputs.
REQ-010 Port launch SHALL be: output, 1 bit; registered race pulse driving both inputs of the first switch stage.
REQ-011 Port arb_out SHALL be: input, 1 bit; asynchronous arbiter latch output.
REQ-012 Port resp SHALL be: output, 1 bit; majority-voted response bit.
REQ-013 Port resp_ones SHALL be: output, $clog2(NUM_EVAL+1) bits; count of races that returned 1.
REQ-014 Port resp_valid SHALL be: output, 1 bit; response available.
REQ-015 Port resp_ready SHALL be: input, 1 bit; consumer accepts the response.

Function
REQ-016 arb_out SHALL pass through a 2-flop synchroniser before any use; arb_s is the second flop.
REQ-017 The FSM SHALL have exactly these states: IDLE, ARM, FIRE, SAMPLE, DONE.
REQ-018 In IDLE, start=1 SHALL register chal_in into chal_out, clear the race counter and the ones counter, and move to ARM on the next edge.
REQ-019 ARM SHALL hold launch=0 for exactly SETTLE_CYC cycles, then move to FIRE.
REQ-020 FIRE SHALL hold launch=1 for exactly SETTLE_CYC cycles, then move to SAMPLE.
REQ-021 SAMPLE SHALL last one cycle, drive launch=0, add arb_s to the ones counter and increment the race counter.
REQ-022 After SAMPLE, the FSM SHALL go to DONE if the race counter reaches NUM_EVAL; otherwise it SHALL go to ARM.
REQ-023 Per-race period SHALL be 2*SETTLE_CYC+1 cycles.
REQ-024 resp_valid SHALL rise exactly 1+NUM_EVAL*(2*SETTLE_CYC+1) cycles after the edge that accepts start.
REQ-025 In DONE: resp_valid=1; resp_ones=final count; resp=1 iff resp_ones > NUM_EVAL/2 (integer division).
REQ-026 resp, resp_ones and resp_valid SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-027 In DONE, resp_ready=1 SHALL return the FSM to IDLE on that edge and deassert resp_valid and busy.
REQ-028 A start asserted in the same cycle as that handshake SHALL be ignored; it is accepted only from IDLE.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 chal_out SHALL change only on start acceptance and SHALL stay constant through all NUM_EVAL races.
REQ-031 launch SHALL be glitch-free: driven directly from a flop, never decoded combinationally.
REQ-032 The ones counter SHALL NOT wrap; its width holds NUM_EVAL exactly.
REQ-033 Illegal parameter values (even NUM_EVAL, SETTLE_CYC<3) SHALL stop elaboration with an error.

Reset
REQ-034 rst_n=0 SHALL immediately, regardless of clk, force: state=IDLE, launch=0, busy=0, resp_valid=0, resp=0, resp_ones=0, chal_out=0, counters=0, synchroniser flops=0.
REQ-035 Reset asserted mid-race SHALL abort the evaluation with no response produced; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-036 The bench SHALL cover: SETTLE_CYC=4, NUM_EVAL=3, chal_in=64'hA5A5_0000_FFFF_1234, arb_out tied 1, start pulse -> chal_out=that value, three launch-high windows of 4 cycles, resp_valid at +28 cycles, resp=1, resp_ones=2'd3.
REQ-037 The bench SHALL cover: same parameters, arb_out=1 only during the 2nd race -> resp=0, resp_ones=1.
REQ-038 The bench SHALL cover: resp_ready held 0 for 10 cycles after resp_valid -> outputs stable; start pulses during this time ignored; resp_ready=1 -> IDLE next edge, busy=0.
REQ-039 The bench SHALL cover: start plus a new chal_in during the 2nd race -> chal_out unchanged, exactly 3 races run.
REQ-040 The bench SHALL cover: rst_n low during a FIRE phase -> launch=0 and busy=0 before the next clk edge; no resp_valid after release.
REQ-041 The bench SHALL cover: defaults (64/8/15), arb_out random with p=0.7 over 200 challenges -> resp equals the majority of the sampled bits, with latency 256 cycles each time.

Source files
------------

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller.
// Loads a challenge into the switch chain, fires NUM_EVAL races through it,
// counts how many races the arbiter resolved to 1, and returns the majority
// vote together with that count.
//
// Response handshake: resp_valid is raised once the final count has been
// folded into resp/resp_ones. resp, resp_ones and resp_valid hold steady
// until a cycle in which resp_valid and resp_ready are both high; on that
// edge the transfer completes, resp_valid and busy drop, and the controller
// returns to IDLE. A start seen during that same cycle is not accepted,
// because start is only looked at in IDLE.
module apuf_eval_ctrl #(
  parameter int CHAL_W     = 64,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_EVAL   = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CHAL_W-1:0]               chal_in,
  output logic                            busy,
  output logic [CHAL_W-1:0]               chal_out,
  output logic                            launch,
  input  logic                            arb_out,
  output logic                            resp,
  output logic [$clog2(NUM_EVAL+1)-1:0]   resp_ones,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [2:0]                      dbg_state
);

  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam logic [7:0]       PHASE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RACE_LAST  = CNT_W'(NUM_EVAL - 1);
  localparam logic [CNT_W-1:0] HALF       = CNT_W'(NUM_EVAL / 2);

  // Refuse to build with parameters the timing or the vote cannot support.
  if (SETTLE_CYC < 3 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("apuf_eval_ctrl: SETTLE_CYC must be in 3..255");
  end
  if (NUM_EVAL < 1 || NUM_EVAL > 255 || (NUM_EVAL % 2) == 0) begin : g_bad_eval
    $error("apuf_eval_ctrl: NUM_EVAL must be odd and in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FIRE   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       phase_cnt;
  logic [CNT_W-1:0] race_cnt;
  logic             phase_last;
  logic             arb_m;
  logic             arb_s;

  assign phase_last = (phase_cnt == PHASE_LAST);
  assign dbg_state  = state;

  // Two-flop synchroniser for the asynchronous arbiter latch output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_m <= 1'b0;
      arb_s <= 1'b0;
    end else begin
      arb_m <= arb_out;
      arb_s <= arb_m;
    end
  end

  // Next-state decode: relax (ARM), race (FIRE), capture (SAMPLE), report (DONE).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     if (phase_last) state_next = FIRE;
      FIRE:    if (phase_last) state_next = SAMPLE;
      SAMPLE:  state_next = (race_cnt == RACE_LAST) ? DONE : ARM;
      DONE:    if (resp_valid && resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, datapath counters and registered outputs.
  // launch is taken from a flop loaded with the upcoming state so the race
  // pulse is aligned with FIRE and never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      launch     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp       <= 1'b0;
      resp_ones  <= '0;
      chal_out   <= '0;
      phase_cnt  <= '0;
      race_cnt   <= '0;
    end else begin
      state  <= state_next;
      launch <= (state_next == FIRE);
      case (state)
        IDLE: begin
          if (start) begin
            chal_out  <= chal_in;
            race_cnt  <= '0;
            resp_ones <= '0;
            phase_cnt <= '0;
            resp      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ARM, FIRE: begin
          phase_cnt <= phase_last ? 8'd0 : phase_cnt + 8'd1;
        end
        SAMPLE: begin
          resp_ones <= resp_ones + CNT_W'(arb_s);
          race_cnt  <= race_cnt + CNT_W'(1);
        end
        DONE: begin
          // First DONE cycle latches the vote; afterwards wait for the consumer.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp       <= (resp_ones > HALF);
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
